// File: rtl/matmul_engine.sv
// -----------------------------------------------------------------------------
// matmul_engine
// Sequential square matrix multiplier: C = A x B, one multiply-accumulate per
// clock. Operands are captured on the accepting edge, so the inputs may change
// freely while a job is running. Each finished C element is written in place
// (row-major order, k innermost). All other C elements keep their previous
// values.
//
// Ports
//   clk    in   1            rising-edge clock
//   rst_n  in   1            asynchronous active-low reset
//   start  in   1            request a job (accepted in IDLE or DONE)
//   a_in   in   N*N*DATA_W   matrix A, element (r,c) at [(r*N+c)*DATA_W +: DATA_W]
//   b_in   in   N*N*DATA_W   matrix B, same packing
//   c_out  out  N*N*OUT_W    matrix C, element (r,c) at [(r*N+c)*OUT_W +: OUT_W]
//   busy   out  1            high exactly while computing
//   done   out  1            one-cycle completion pulse
// -----------------------------------------------------------------------------
module matmul_engine #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16,
    parameter int SIGNED = 0,
    parameter int SAT    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [N*N*DATA_W-1:0]     a_in,
    input  logic [N*N*DATA_W-1:0]     b_in,
    output logic [N*N*OUT_W-1:0]      c_out,
    output logic                      busy,
    output logic                      done
);

    localparam int IDX_W = $clog2(N);
    localparam int ACC_W = 2 * DATA_W + $clog2(N);
    // Saturation works on a value strictly wider than OUT_W so that the
    // overflow bits always exist, even for narrow operand configurations.
    localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                  state_q;
    logic [N*N*DATA_W-1:0]   a_q;
    logic [N*N*DATA_W-1:0]   b_q;
    logic [N*N*OUT_W-1:0]    c_q;
    logic [ACC_W-1:0]        acc_q;
    logic [IDX_W-1:0]        i_q;
    logic [IDX_W-1:0]        j_q;
    logic [IDX_W-1:0]        k_q;
    logic                    busy_q;
    logic                    done_q;

    logic [DATA_W-1:0]       a_el_s;
    logic [DATA_W-1:0]       b_el_s;
    logic [ACC_W-1:0]        a_ext_s;
    logic [ACC_W-1:0]        b_ext_s;
    logic [ACC_W-1:0]        prod_s;
    logic [ACC_W-1:0]        sum_s;
    logic [EXT_W-1:0]        sum_ext_s;
    logic [OUT_W-1:0]        res_s;
    logic                    last_k_s;
    logic                    last_j_s;
    logic                    last_i_s;

    // Clamp a wide sum into the OUT_W range of the configured signedness.
    function automatic logic [OUT_W-1:0] sat_clamp(input logic [EXT_W-1:0] v);
        logic [EXT_W-OUT_W:0] hi;
        logic [OUT_W-1:0]     r;
        hi = v[EXT_W-1:OUT_W-1];
        if (SIGNED != 0) begin
            // Fits when every bit from the OUT_W sign bit upward agrees.
            if ((&hi) || !(|hi)) begin
                r = v[OUT_W-1:0];
            end else if (v[EXT_W-1]) begin
                r = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                r = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end else begin
            if (|v[EXT_W-1:OUT_W]) begin
                r = {OUT_W{1'b1}};
            end else begin
                r = v[OUT_W-1:0];
            end
        end
        return r;
    endfunction

    // Datapath: select operands, extend, multiply-accumulate, and format the result.
    always_comb begin
        a_el_s = a_q[(int'(i_q) * N + int'(k_q)) * DATA_W +: DATA_W];
        b_el_s = b_q[(int'(k_q) * N + int'(j_q)) * DATA_W +: DATA_W];
        if (SIGNED != 0) begin
            a_ext_s = ACC_W'($signed(a_el_s));
            b_ext_s = ACC_W'($signed(b_el_s));
        end else begin
            a_ext_s = ACC_W'(a_el_s);
            b_ext_s = ACC_W'(b_el_s);
        end
        // Low ACC_W bits of the product are identical for signed and unsigned.
        prod_s = a_ext_s * b_ext_s;
        sum_s  = acc_q + prod_s;
        if (SIGNED != 0) begin
            sum_ext_s = EXT_W'($signed(sum_s));
        end else begin
            sum_ext_s = EXT_W'(sum_s);
        end
        if (SAT != 0) begin
            res_s = sat_clamp(sum_ext_s);
        end else begin
            res_s = sum_ext_s[OUT_W-1:0];
        end
        last_k_s = (k_q == IDX_W'(N - 1));
        last_j_s = (j_q == IDX_W'(N - 1));
        last_i_s = (i_q == IDX_W'(N - 1));
    end

    // Control FSM with operand capture, counters, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= COMPUTE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                COMPUTE: begin
                    if (last_k_s) begin
                        // Element complete: publish it and restart the sum
                        // for the next element on the very next cycle.
                        c_q[(int'(i_q) * N + int'(j_q)) * OUT_W +: OUT_W] <= res_s;
                        acc_q <= '0;
                        k_q   <= '0;
                        if (last_j_s) begin
                            j_q <= '0;
                            if (last_i_s) begin
                                i_q     <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                i_q <= i_q + IDX_W'(1);
                            end
                        end else begin
                            j_q <= j_q + IDX_W'(1);
                        end
                    end else begin
                        acc_q <= sum_s;
                        k_q   <= k_q + IDX_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign c_out = c_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/matmul_engine.md
MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning matrix dimension (square N x N, N >= 2).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning operand element width.
REQ-003 The block SHALL have parameter OUT_W, default 16, meaning result element width.
REQ-004 The block SHALL have parameter SIGNED, default 0, meaning operands and results are two's complement when 1 and unsigned when 0.
REQ-005 The block SHALL have parameter SAT, default 1, meaning results are clamped to the OUT_W range when 1 and truncated to the low OUT_W bits when 0.
REQ-006 The block SHALL use one clock and an asynchronous active-low reset, with ports named clk and rst_n as in the rest of the codebase.
REQ-007 Port list (name, direction, width, meaning):
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: request to compute C = A x B.
- a_in, in, N*N*DATA_W: matrix A; element (r,c) at bits [(r*N+c)*DATA_W +: DATA_W].
- b_in, in, N*N*DATA_W: matrix B; same packing as a_in.
- c_out, out, N*N*OUT_W: matrix C; element (r,c) at bits [(r*N+c)*OUT_W +: OUT_W].
- busy, out, 1: computation in progress.
- done, out, 1: single-cycle completion pulse.

Function
REQ-008 States SHALL be IDLE, COMPUTE and DONE.
REQ-009 In IDLE or DONE, start=1 at a rising edge SHALL snapshot a_in and b_in into internal registers, clear the accumulator and the i/j/k counters, and enter COMPUTE.
REQ-010 a_in and b_in SHALL be ignored outside the accepting edge; changing them during COMPUTE SHALL NOT affect the result.
REQ-011 COMPUTE SHALL perform exactly one multiply-accumulate per cycle, acc += A[i][k]*B[k][j], with k innermost, then j, then i.
REQ-012 When k=N-1, the completed sum SHALL be written to C[i][j], the accumulator SHALL be cleared, and the next element SHALL begin on the following cycle with no bubble.
REQ-013 The internal accumulator SHALL be 2*DATA_W+clog2(N) bits wide so that it never overflows.
REQ-014 Products and sums SHALL be signed when SIGNED=1 and unsigned otherwise.
REQ-015 When SAT=1, each C element SHALL be clamped to [0, 2^OUT_W-1] when unsigned or to [-2^(OUT_W-1), 2^(OUT_W-1)-1] when signed.
REQ-016 When SAT=0, each C element SHALL be the low OUT_W bits of the sum.
REQ-017 After the N^3-th COMPUTE edge, counted from the accept edge, the state SHALL be DONE, done SHALL be 1 and busy SHALL be 0.
REQ-018 done SHALL be high for exactly one cycle; with no start in that cycle, the next edge SHALL go DONE -> IDLE.
REQ-019 busy SHALL be 1 exactly while the state is COMPUTE.
REQ-020 start SHALL be ignored while busy=1; the in-flight result SHALL be unaffected.
REQ-021 start=1 during DONE SHALL be accepted per REQ-009, giving back-to-back operation with one done cycle between jobs.
REQ-022 c_out elements SHALL update only at their write in REQ-012 and SHALL otherwise hold their values, including across IDLE and into the next job.

Reset
REQ-023 rst_n=0 SHALL immediately, asynchronously force state=IDLE, busy=0, done=0, c_out=0, accumulator=0, counters=0 and operand registers=0.
REQ-024 Reset during COMPUTE SHALL discard the in-flight job, with no done pulse and no partial c_out retained.
REQ-025 start SHALL be ignored while rst_n=0; after deassertion, the first edge with start=1 SHALL accept normally.

Verification (N=4, DATA_W=8, OUT_W=16 unless noted)
REQ-026 A all 2, B all 4, SIGNED=0, start pulsed at edge 0 -> busy for 64 cycles; done=1 only after edge 64; every C element = 32.
REQ-027 A = identity, B = elements 0..15 in row-major order -> C = B exactly; repeat with A and B swapped -> same C.
REQ-028 A all 255, B all 255, SIGNED=0 -> SAT=1 gives every C = 65535; SAT=0 gives every C = 63492 (260100 mod 65536).
REQ-029 SIGNED=1, A all 8'hFF (-1), B all 2 -> every C = 16'hFFF8 (-8); with A all -128, B all -128, SAT=1 -> every C = 32767.
REQ-030 Start a job, pulse start again at cycle 10, change a_in at cycle 20, assert rst_n=0 at cycle 40 -> cycles 10 and 20 have no effect; at reset busy=0, done=0, c_out=0 immediately; a fresh job then completes correctly in 64 cycles.
REQ-031 Hold start=1 continuously for three jobs with different operands -> done pulses 65 cycles apart; each job's c_out is correct and is held until overwritten element by element.
